mem_if_arbiter: RTL and testbench
=================================

# mem_if_arbiter

Round-robin command arbiter and read-response router that shares one `mem_if` DDR bridge between `NUM_REQ` requesters in the `Clk_400` domain. It accepts write/read commands from each requester and issues them one at a time on the `mem_if` command port, respecting `cmd_fifo_full`. It records the requester of every read in an in-order tag FIFO, pops `mem_if` read data as it arrives and steers each returned word to the requester that issued the read.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `DATA_WIDTH`, 64, data width
- `ADDR_WIDTH`, 26, address width
- `BYTEEN_WIDTH`, 8, byte-enable width
- `BURSTCOUNT_WIDTH`, 7, burstcount width
- `TAG_DEPTH`, 16, maximum outstanding reads (power of 2)
- `RD_LATENCY`, 2, cycles from `read_ddr_data` to valid `readdata`

Clock and reset are fixed: one clock; reset is synchronous and active-high.

- `Clk_400`  in  1  sole clock
- `SoftReset`  in  1  synchronous, active-high reset
- `req_write`  in  NUM_REQ  per-requester write request, held until granted
- `req_read`  in  NUM_REQ  per-requester read request, held until granted
- `req_address`  in  NUM_REQ*ADDR_WIDTH  packed, requester i at slice i
- `req_writedata`  in  NUM_REQ*DATA_WIDTH  packed write data
- `req_byteenable`  in  NUM_REQ*BYTEEN_WIDTH  packed byte enables
- `req_burstcount`  in  NUM_REQ*BURSTCOUNT_WIDTH  packed burstcounts
- `req_readdata_sel`  in  NUM_REQ*3  packed 64-bit word select
- `req_grant`  out  NUM_REQ  one-hot, single-cycle acceptance pulse
- `rsp_valid`  out  NUM_REQ  one-hot read-data valid pulse
- `rsp_data`  out  DATA_WIDTH  read data, shared bus
- `write`, `read`  out  1 each  command strobes to `mem_if`, never both high
- `address`, `writedata`, `byteenable`, `burstcount`, `readdata_sel`  out  matching widths  command fields to `mem_if`
- `cmd_fifo_full`  in  1  from `mem_if`
- `ddr_data_ready`  in  1  from `mem_if`, read data available
- `read_ddr_data`  out  1  pop strobe to `mem_if`
- `readdata`  in  DATA_WIDTH  from `mem_if`
- `rd_outstanding`  out  $clog2(TAG_DEPTH)+1  count of reads issued but not yet returned
- `rsp_orphan`  out  1  sticky error: data popped while the tag FIFO was empty

## Operation
- **Command register.** A single-entry output register holds {cmd, fields, requester id}.
  - Accept condition: `(write|read) & ~cmd_fifo_full`.
  - While not accepted, the register holds its contents stable.
  - It may load in a cycle when it is empty or its current command is accepted.
- **Arbitration.**
  - Eligible requester: `req_write[i]`, or `req_read[i]` with reads-in-flight < `TAG_DEPTH`.
  - Reads-in-flight = `rd_outstanding` + a read held in the register.
  - If a requester asserts both write and read, write wins.
  - Search order starts at the last-granted requester + 1, wrapping modulo `NUM_REQ`.
  - The pointer updates only on a grant. After reset, the pointer is `NUM_REQ-1`, so requester 0 is searched first.
- **Grant.** `req_grant[i]` is combinational in the load cycle. The requester deasserts or presents its next command on the following cycle.
- **Tag FIFO.**
  - Depth `TAG_DEPTH`; stores the requester id.
  - Pushed when a read is accepted by `mem_if`, not when it is loaded.
  - `rd_outstanding` increments on push and decrements on pop; a simultaneous push and pop leaves it unchanged.
- **Return path.**
  - `read_ddr_data = ddr_data_ready`, asserted every cycle data is available.
  - On each pop, the tag FIFO is popped and {valid, id} enters an `RD_LATENCY`-deep shift pipe.
  - At the pipe output, `rsp_valid[id]` pulses and `rsp_data = readdata` (registered).
  - Pop with an empty tag FIFO: the data is discarded, `rsp_orphan` sets, and `rd_outstanding` stays at 0.
- **Reset.** `SoftReset` clears the register, strobes, tag FIFO, pipe, pointer and `rsp_orphan`. In-flight reads are abandoned; `mem_if` FIFOs are cleared by the same reset.

## Timing
- Reset values: `write`, `read`, `read_ddr_data`, `req_grant`, `rsp_valid`, `rsp_orphan` = 0; `rd_outstanding` = 0; command fields = 0; `rsp_data` = 0.
- Issue latency: request at cycle t with an empty register gives grant at t and strobe at t+1.
- Throughput: one command per cycle sustained while `cmd_fifo_full` = 0.
- `cmd_fifo_full` high during a strobe cycle: the strobe and fields hold, and no grant is issued.
- Response latency: pop at cycle p gives `rsp_valid` at p+`RD_LATENCY`+1.
  - `readdata` is sampled at p+`RD_LATENCY`.
  - The sampled value is registered onto `rsp_data`.
- Responses return in issue order across all requesters.

## Test plan
- **Basic issue and return:** requester 0 reads at 0x100.
  - `req_grant` = 0001 at t, `read` = 1 at t+1.
  - Then `ddr_data_ready` with data 0xA5 → `rsp_valid` = 0001 and `rsp_data` = 0xA5 three cycles after the pop.
- **Fairness:** all 4 requesters hold writes continuously, `cmd_fifo_full` = 0 → grants 0,1,2,3,0,… and one `write` per cycle.
- **Backpressure:** `cmd_fifo_full` = 1 for 5 cycles while a write is pending.
  - `write` is held with stable fields and no new grants.
  - The command is accepted on the first cycle full = 0.
- **Tag limit:** 16 reads accepted with no return.
  - A 17th read is not granted, while a write from another requester is still granted.
  - One return pops and `rd_outstanding` 16 → 15, after which the read is granted.
- **Routing:** reads issued by requesters 2, 0, 3 return data 1, 2, 3 → `rsp_valid` sequence 0100, 0001, 1000 with the matching data.
- **Error and reset:** `ddr_data_ready` with no outstanding reads sets `rsp_orphan` = 1. `SoftReset` mid-burst clears all outputs to their reset values within one cycle.

Source files
------------

// File: rtl/mem_if_arbiter.sv
// Round-robin command arbiter sharing one mem_if bridge between requesters,
// with an in-order tag FIFO that steers returned read data back to its issuer.
module mem_if_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int DATA_WIDTH       = 64,
    parameter int ADDR_WIDTH       = 26,
    parameter int BYTEEN_WIDTH     = 8,
    parameter int BURSTCOUNT_WIDTH = 7,
    parameter int TAG_DEPTH        = 16,
    parameter int RD_LATENCY       = 2
) (
    input  logic                                  Clk_400,
    input  logic                                  SoftReset,
    input  logic [NUM_REQ-1:0]                    req_write,
    input  logic [NUM_REQ-1:0]                    req_read,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]         req_address,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]         req_writedata,
    input  logic [NUM_REQ*BYTEEN_WIDTH-1:0]       req_byteenable,
    input  logic [NUM_REQ*BURSTCOUNT_WIDTH-1:0]   req_burstcount,
    input  logic [NUM_REQ*3-1:0]                  req_readdata_sel,
    output logic [NUM_REQ-1:0]                    req_grant,
    output logic [NUM_REQ-1:0]                    rsp_valid,
    output logic [DATA_WIDTH-1:0]                 rsp_data,
    output logic                                  write,
    output logic                                  read,
    output logic [ADDR_WIDTH-1:0]                 address,
    output logic [DATA_WIDTH-1:0]                 writedata,
    output logic [BYTEEN_WIDTH-1:0]               byteenable,
    output logic [BURSTCOUNT_WIDTH-1:0]           burstcount,
    output logic [2:0]                            readdata_sel,
    input  logic                                  cmd_fifo_full,
    input  logic                                  ddr_data_ready,
    output logic                                  read_ddr_data,
    input  logic [DATA_WIDTH-1:0]                 readdata,
    output logic [$clog2(TAG_DEPTH):0]            rd_outstanding,
    output logic                                  rsp_orphan
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int AW  = $clog2(TAG_DEPTH);
    localparam int CW  = AW + 1;

    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     sel;
    logic [IDW-1:0]     cmd_id;
    logic               found;
    logic               accept;
    logic               can_load;
    logic               load;
    logic               sel_write;
    logic               rd_ok;
    logic [CW:0]        in_flight;
    logic [NUM_REQ-1:0] eligible;

    logic [IDW-1:0]     tag_mem [TAG_DEPTH];
    logic [AW-1:0]      wptr;
    logic [AW-1:0]      rptr;
    logic               push;
    logic               pop;
    logic               orphan_ev;

    logic [RD_LATENCY-1:0] pipe_v;
    logic [IDW-1:0]        pipe_id [RD_LATENCY];

    assign accept   = (write | read) & ~cmd_fifo_full;
    assign can_load = ~(write | read) | accept;

    // A read parked in the command register already owns a tag slot.
    assign in_flight = {1'b0, rd_outstanding} + (CW+1)'(read);
    assign rd_ok     = in_flight < (CW+1)'(TAG_DEPTH);
    assign eligible  = req_write | (req_read & {NUM_REQ{rd_ok}});

    always_comb begin
        found = 1'b0;
        sel   = ptr;
        for (int k = 1; k <= NUM_REQ; k++) begin
            logic [IDW-1:0] j;
            j = IDW'((int'(ptr) + k) % NUM_REQ);
            if (!found && eligible[j]) begin
                found = 1'b1;
                sel   = j;
            end
        end
    end

    assign load      = can_load & found & ~SoftReset;
    assign sel_write = req_write[sel];
    assign req_grant = load ? (NUM_REQ'(1) << sel) : '0;

    always_ff @(posedge Clk_400) begin
        if (SoftReset) begin
            write        <= 1'b0;
            read         <= 1'b0;
            address      <= '0;
            writedata    <= '0;
            byteenable   <= '0;
            burstcount   <= '0;
            readdata_sel <= '0;
            cmd_id       <= '0;
            ptr          <= IDW'(NUM_REQ-1);
        end else if (load) begin
            write        <= sel_write;
            read         <= ~sel_write;
            address      <= req_address[sel*ADDR_WIDTH +: ADDR_WIDTH];
            writedata    <= req_writedata[sel*DATA_WIDTH +: DATA_WIDTH];
            byteenable   <= req_byteenable[sel*BYTEEN_WIDTH +: BYTEEN_WIDTH];
            burstcount   <= req_burstcount[sel*BURSTCOUNT_WIDTH +: BURSTCOUNT_WIDTH];
            readdata_sel <= req_readdata_sel[sel*3 +: 3];
            cmd_id       <= sel;
            ptr          <= sel;
        end else if (accept) begin
            write <= 1'b0;
            read  <= 1'b0;
        end
    end

    // Tags enter only when mem_if actually takes the read.
    assign push          = read & ~cmd_fifo_full;
    assign read_ddr_data = ddr_data_ready & ~SoftReset;
    assign pop           = ddr_data_ready & (rd_outstanding != '0);
    assign orphan_ev     = ddr_data_ready & (rd_outstanding == '0);

    always_ff @(posedge Clk_400) begin
        if (push) begin
            tag_mem[wptr] <= cmd_id;
        end
    end

    always_ff @(posedge Clk_400) begin
        if (SoftReset) begin
            wptr           <= '0;
            rptr           <= '0;
            rd_outstanding <= '0;
            rsp_orphan     <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            if (push && !pop) begin
                rd_outstanding <= rd_outstanding + CW'(1);
            end else if (pop && !push) begin
                rd_outstanding <= rd_outstanding - CW'(1);
            end
            if (orphan_ev) begin
                rsp_orphan <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk_400) begin
        if (SoftReset) begin
            pipe_v    <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                pipe_id[k] <= '0;
            end
        end else begin
            pipe_v[0]  <= pop;
            pipe_id[0] <= tag_mem[rptr];
            for (int k = 1; k < RD_LATENCY; k++) begin
                pipe_v[k]  <= pipe_v[k-1];
                pipe_id[k] <= pipe_id[k-1];
            end
            if (pipe_v[RD_LATENCY-1]) begin
                rsp_valid <= NUM_REQ'(1) << pipe_id[RD_LATENCY-1];
                rsp_data  <= readdata;
            end else begin
                rsp_valid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_if_arbiter.sv
// Directed bench for mem_if_arbiter: issue, fairness, backpressure,
// tag limit, routing, orphan detection and reset.
module tb_mem_if_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int AWD = 26;
    localparam int BW = 8;
    localparam int BCW = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_write;
    logic [N-1:0]     req_read;
    logic [N*AWD-1:0] req_address;
    logic [N*DW-1:0]  req_writedata;
    logic [N*BW-1:0]  req_byteenable;
    logic [N*BCW-1:0] req_burstcount;
    logic [N*3-1:0]   req_readdata_sel;
    logic [N-1:0]     req_grant;
    logic [N-1:0]     rsp_valid;
    logic [DW-1:0]    rsp_data;
    logic             write;
    logic             read;
    logic [AWD-1:0]   address;
    logic [DW-1:0]    writedata;
    logic [BW-1:0]    byteenable;
    logic [BCW-1:0]   burstcount;
    logic [2:0]       readdata_sel;
    logic             cmd_fifo_full;
    logic             ddr_data_ready;
    logic             read_ddr_data;
    logic [DW-1:0]    readdata;
    logic [4:0]       rd_outstanding;
    logic             rsp_orphan;

    int total = 0;
    int bad = 0;
    int n;

    mem_if_arbiter dut (
        .Clk_400          (clk),
        .SoftReset        (rst),
        .req_write        (req_write),
        .req_read         (req_read),
        .req_address      (req_address),
        .req_writedata    (req_writedata),
        .req_byteenable   (req_byteenable),
        .req_burstcount   (req_burstcount),
        .req_readdata_sel (req_readdata_sel),
        .req_grant        (req_grant),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .write            (write),
        .read             (read),
        .address          (address),
        .writedata        (writedata),
        .byteenable       (byteenable),
        .burstcount       (burstcount),
        .readdata_sel     (readdata_sel),
        .cmd_fifo_full    (cmd_fifo_full),
        .ddr_data_ready   (ddr_data_ready),
        .read_ddr_data    (read_ddr_data),
        .readdata         (readdata),
        .rd_outstanding   (rd_outstanding),
        .rsp_orphan       (rsp_orphan)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_write = '0;
        req_read = '0;
        req_address = '0;
        req_writedata = '0;
        req_byteenable = '0;
        req_burstcount = '0;
        req_readdata_sel = '0;
        cmd_fifo_full = 1'b0;
        ddr_data_ready = 1'b0;
        readdata = '0;
        for (int i = 0; i < N; i++) begin
            req_address[i*AWD +: AWD] = AWD'(32'h200 + i);
        end

        // reset values, with requests and data-ready pressing on the inputs
        cyc();
        req_write = 4'b1111;
        ddr_data_ready = 1'b1;
        cyc();
        chk("rst_grant", 64'(req_grant), 64'h0);
        chk("rst_write", 64'(write), 64'h0);
        chk("rst_read", 64'(read), 64'h0);
        chk("rst_rdd", 64'(read_ddr_data), 64'h0);
        chk("rst_rspv", 64'(rsp_valid), 64'h0);
        chk("rst_orphan", 64'(rsp_orphan), 64'h0);
        chk("rst_outst", 64'(rd_outstanding), 64'h0);
        chk("rst_addr", 64'(address), 64'h0);
        chk("rst_rdata", rsp_data, 64'h0);
        req_write = '0;
        ddr_data_ready = 1'b0;
        rst = 1'b0;
        cyc();

        // basic issue and return
        req_read[0] = 1'b1;
        req_address[0 +: AWD] = AWD'(32'h100);
        #1;
        chk("basic_grant", 64'(req_grant), 64'h1);
        cyc();
        req_read[0] = 1'b0;
        #1;
        chk("basic_read", 64'(read), 64'h1);
        chk("basic_write", 64'(write), 64'h0);
        chk("basic_addr", 64'(address), 64'h100);
        chk("basic_grant0", 64'(req_grant), 64'h0);
        cyc();
        chk("basic_rd_clr", 64'(read), 64'h0);
        chk("basic_outst1", 64'(rd_outstanding), 64'h1);
        ddr_data_ready = 1'b1;
        #1;
        chk("basic_rdd", 64'(read_ddr_data), 64'h1);
        cyc();
        ddr_data_ready = 1'b0;
        #1;
        chk("basic_outst0", 64'(rd_outstanding), 64'h0);
        chk("basic_early", 64'(rsp_valid), 64'h0);
        cyc();
        readdata = 64'hA5;
        #1;
        chk("basic_early2", 64'(rsp_valid), 64'h0);
        cyc();
        readdata = '0;
        #1;
        chk("basic_rspv", 64'(rsp_valid), 64'h1);
        chk("basic_rspd", rsp_data, 64'hA5);
        cyc();
        chk("basic_rspv_end", 64'(rsp_valid), 64'h0);

        // fairness: pointer sits at 0, so requester 1 is searched first
        req_address[0 +: AWD] = AWD'(32'h200);
        req_write = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("fair_grant", 64'(req_grant), 64'(4'b0001 << ((1 + k) % 4)));
            if (k > 0) begin
                chk("fair_write", 64'(write), 64'h1);
                chk("fair_addr", 64'(address), 64'(32'h200 + (k % 4)));
            end
            cyc();
        end
        req_write = '0;
        #1;
        chk("fair_last_wr", 64'(write), 64'h1);
        chk("fair_last_ad", 64'(address), 64'h200);
        chk("fair_nogrant", 64'(req_grant), 64'h0);
        cyc();
        chk("fair_idle", 64'(write), 64'h0);

        // backpressure
        req_write[2] = 1'b1;
        req_address[2*AWD +: AWD] = AWD'(32'h3C0);
        req_address[3*AWD +: AWD] = AWD'(32'h3C3);
        req_writedata[2*DW +: DW] = 64'hDEAD;
        #1;
        chk("bp_grant", 64'(req_grant), 64'h4);
        cyc();
        req_write[2] = 1'b0;
        req_write[3] = 1'b1;
        cmd_fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_hold_wr", 64'(write), 64'h1);
            chk("bp_hold_ad", 64'(address), 64'h3C0);
            chk("bp_hold_wd", writedata, 64'hDEAD);
            chk("bp_nogrant", 64'(req_grant), 64'h0);
            cyc();
        end
        cmd_fifo_full = 1'b0;
        #1;
        chk("bp_rel_wr", 64'(write), 64'h1);
        chk("bp_rel_ad", 64'(address), 64'h3C0);
        chk("bp_rel_grant", 64'(req_grant), 64'h8);
        cyc();
        req_write[3] = 1'b0;
        #1;
        chk("bp_next_wr", 64'(write), 64'h1);
        chk("bp_next_ad", 64'(address), 64'h3C3);
        cyc();
        chk("bp_idle", 64'(write), 64'h0);

        // tag limit: requester 1 reads with no returns
        req_read[1] = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (req_grant == 4'b0010) n++;
            cyc();
        end
        chk("tag_grants", 64'(n), 64'd16);
        chk("tag_outst16", 64'(rd_outstanding), 64'd16);
        chk("tag_rd_idle", 64'(read), 64'h0);
        req_write[3] = 1'b1;
        #1;
        chk("tag_wr_grant", 64'(req_grant), 64'h8);
        cyc();
        req_write[3] = 1'b0;
        #1;
        chk("tag_wr_issue", 64'(write), 64'h1);
        chk("tag_rd_block", 64'(req_grant), 64'h0);
        cyc();
        chk("tag_wr_done", 64'(write), 64'h0);
        chk("tag_outst_b", 64'(rd_outstanding), 64'd16);
        ddr_data_ready = 1'b1;
        #1;
        chk("tag_pop_blk", 64'(req_grant), 64'h0);
        cyc();
        ddr_data_ready = 1'b0;
        #1;
        chk("tag_outst15", 64'(rd_outstanding), 64'd15);
        chk("tag_rd_grant", 64'(req_grant), 64'h2);
        cyc();
        req_read[1] = 1'b0;
        readdata = 64'h77;
        #1;
        chk("tag_rd_issue", 64'(read), 64'h1);
        cyc();
        readdata = '0;
        #1;
        chk("tag_rspv", 64'(rsp_valid), 64'h2);
        chk("tag_rspd", rsp_data, 64'h77);
        chk("tag_outst_r", 64'(rd_outstanding), 64'd16);

        // reset in the middle of a return burst with a write pending
        cyc();
        ddr_data_ready = 1'b1;
        req_write[0] = 1'b1;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        chk("mrst_write", 64'(write), 64'h0);
        chk("mrst_read", 64'(read), 64'h0);
        chk("mrst_grant", 64'(req_grant), 64'h0);
        chk("mrst_rspv", 64'(rsp_valid), 64'h0);
        chk("mrst_rdd", 64'(read_ddr_data), 64'h0);
        chk("mrst_outst", 64'(rd_outstanding), 64'h0);
        chk("mrst_addr", 64'(address), 64'h0);
        chk("mrst_rdata", rsp_data, 64'h0);
        rst = 1'b0;
        ddr_data_ready = 1'b0;
        req_write = '0;
        cyc();

        // routing: reads from 2, 0, 3 return 1, 2, 3
        req_read[2] = 1'b1;
        #1;
        chk("rt_grant2", 64'(req_grant), 64'h4);
        cyc();
        req_read[2] = 1'b0;
        #1;
        chk("rt_read2", 64'(read), 64'h1);
        cyc();
        req_read[0] = 1'b1;
        #1;
        chk("rt_grant0", 64'(req_grant), 64'h1);
        cyc();
        req_read[0] = 1'b0;
        #1;
        chk("rt_read0", 64'(read), 64'h1);
        cyc();
        req_read[3] = 1'b1;
        #1;
        chk("rt_grant3", 64'(req_grant), 64'h8);
        cyc();
        req_read[3] = 1'b0;
        #1;
        chk("rt_read3", 64'(read), 64'h1);
        cyc();
        chk("rt_outst3", 64'(rd_outstanding), 64'd3);
        ddr_data_ready = 1'b1;
        cyc();
        cyc();
        readdata = 64'd1;
        cyc();
        ddr_data_ready = 1'b0;
        readdata = 64'd2;
        #1;
        chk("rt_v1", 64'(rsp_valid), 64'h4);
        chk("rt_d1", rsp_data, 64'd1);
        cyc();
        readdata = 64'd3;
        #1;
        chk("rt_v2", 64'(rsp_valid), 64'h1);
        chk("rt_d2", rsp_data, 64'd2);
        cyc();
        readdata = '0;
        #1;
        chk("rt_v3", 64'(rsp_valid), 64'h8);
        chk("rt_d3", rsp_data, 64'd3);
        chk("rt_outst0", 64'(rd_outstanding), 64'd0);
        chk("rt_no_orphan", 64'(rsp_orphan), 64'h0);

        // orphan: data with nothing outstanding
        cyc();
        ddr_data_ready = 1'b1;
        #1;
        chk("orph_rdd", 64'(read_ddr_data), 64'h1);
        cyc();
        ddr_data_ready = 1'b0;
        #1;
        chk("orph_flag", 64'(rsp_orphan), 64'h1);
        chk("orph_outst", 64'(rd_outstanding), 64'd0);
        cyc();
        cyc();
        chk("orph_norsp", 64'(rsp_valid), 64'h0);
        chk("orph_sticky", 64'(rsp_orphan), 64'h1);
        rst = 1'b1;
        cyc();
        chk("orph_clear", 64'(rsp_orphan), 64'h0);
        rst = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
